// File: rtl/mem_io_responder.sv
// mem_io_responder: single-cycle byte RAM plus a small memory-mapped I/O block
// (UART TX FIFO, UART RX holding register, cycle counter, halt flag).
// Optional feature: define MEM_IO_CLK_CNT_EN to build the 32-bit cycle counter
// and its read snapshot; without it the counter bytes read as 0x00.
// Address map (bits 17:0 decoded): 0x30000 UART data, 0x30004..0x30007 counter
// bytes / halt on write to 0x30004, other 0x3xxxx read 0x00, everything else RAM.

module mem_io_responder #(
   parameter int MEM_ADDR_WID = 17,
   parameter int TX_DEPTH     = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        sim_halt,
   output logic        tx_overflow
);

   localparam int PTR_WID = $clog2(TX_DEPTH);
   localparam int CNT_WID = PTR_WID + 1;
   localparam logic [17:0] UART_ADDR = 18'h30000;
   localparam logic [17:0] CLK_ADDR  = 18'h30004;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic                    is_io;
   logic                    is_uart;
   logic                    is_clk;
   logic                    ram_we;
   logic                    uart_rd;
   logic                    uart_wr;
   logic                    halt_wr;
   logic [MEM_ADDR_WID-1:0] ram_idx;
   logic [13:0]             unused_addr_hi;

   assign is_io          = (mem_a[17:16] == 2'b11);
   assign is_uart        = (mem_a[17:0] == UART_ADDR);
   assign is_clk         = (mem_a[17:2] == CLK_ADDR[17:2]);
   assign ram_idx        = mem_a[MEM_ADDR_WID-1:0];
   assign unused_addr_hi = mem_a[31:18];

   // CPU accesses are dropped entirely during a reset cycle.
   assign ram_we  = !rst_in && mem_wr && !is_io;
   assign uart_rd = !rst_in && !mem_wr && is_uart;
   assign uart_wr = !rst_in && mem_wr && is_uart && (mem_dout != 8'h00);
   assign halt_wr = !rst_in && mem_wr && (mem_a[17:0] == CLK_ADDR);

   // ---------------------------------------------------------------------
   // RAM
   // ---------------------------------------------------------------------
   logic [7:0] ram [2**MEM_ADDR_WID];
   logic [7:0] ram_q;

   // Byte RAM with registered read: data for this cycle's address appears next cycle.
   // NOTE: storage arrays carry no reset so they map onto block RAM; contents survive rst_in.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         ram[ram_idx] <= mem_dout;
      end
      ram_q <= ram[ram_idx];
   end

   // ---------------------------------------------------------------------
   // Cycle counter (optional)
   // ---------------------------------------------------------------------
   logic [7:0] clk_rd_byte;

`ifdef MEM_IO_CLK_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:8] cnt_snap;
   logic        clk_rd;
   logic [1:0]  clk_byte;

   assign clk_rd   = !rst_in && !mem_wr && is_clk;
   assign clk_byte = mem_a[1:0];

   // Free-running counter; reading byte 0 freezes the upper bytes for the reads that follow.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt <= '0;
         cnt_snap  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (clk_rd && (clk_byte == 2'd0)) begin
            cnt_snap <= cycle_cnt[31:8];
         end
      end
   end

   // Byte 0 comes live from the counter, bytes 1..3 from the snapshot.
   always_comb begin
      clk_rd_byte = cycle_cnt[7:0];
      case (clk_byte)
         2'd1:    clk_rd_byte = cnt_snap[15:8];
         2'd2:    clk_rd_byte = cnt_snap[23:16];
         2'd3:    clk_rd_byte = cnt_snap[31:24];
         default: clk_rd_byte = cycle_cnt[7:0];
      endcase
   end
`else
   assign clk_rd_byte = 8'h00;
`endif

   // ---------------------------------------------------------------------
   // UART RX holding register
   // ---------------------------------------------------------------------
   logic [7:0] rx_reg;
   logic       rx_full;

   assign rx_ready = !rx_full;

   // A load only happens into an empty register, so a coincident read sees the old (empty) state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_reg  <= 8'h00;
         rx_full <= 1'b0;
      end else if (rx_valid && !rx_full) begin
         rx_reg  <= rx_data;
         rx_full <= 1'b1;
      end else if (uart_rd) begin
         rx_full <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // I/O read path
   // ---------------------------------------------------------------------
   logic [7:0] io_rd_data;
   logic [7:0] io_q;
   logic       io_sel_q;

   // I/O read mux; writes and unmapped I/O addresses return zero.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      io_rd_data = 8'h00;
      if (!mem_wr) begin
         if (is_uart) begin
            io_rd_data = rx_full ? rx_reg : 8'h00;
         end else if (is_clk) begin
            io_rd_data = clk_rd_byte;
         end
      end
   end

   // Register the I/O result and the RAM/I/O select; reset forces mem_din to zero.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         io_sel_q <= 1'b1;
         io_q     <= 8'h00;
      end else begin
         io_sel_q <= is_io;
         io_q     <= io_rd_data;
      end
   end

   assign mem_din = io_sel_q ? io_q : ram_q;

   // ---------------------------------------------------------------------
   // UART TX FIFO
   // ---------------------------------------------------------------------
   logic [7:0]         tx_mem [TX_DEPTH];
   logic [PTR_WID-1:0] wr_ptr;
   logic [PTR_WID-1:0] rd_ptr;
   logic [CNT_WID-1:0] tx_cnt;
   logic               push_req;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic [7:0]         push_data;

   assign push_req       = uart_wr || halt_wr;
   assign push_data      = halt_wr ? 8'h00 : mem_dout;
   assign fifo_full      = (tx_cnt == CNT_WID'(TX_DEPTH));
   assign pop            = tx_valid && tx_ready;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign push           = push_req && (!fifo_full || pop);
   assign tx_valid       = (tx_cnt != '0);
   assign tx_data        = tx_mem[rd_ptr];
   assign io_buffer_full = (tx_cnt >= CNT_WID'(TX_DEPTH - 2));

   // FIFO storage write port.
   always_ff @(posedge clk_in) begin
      if (push) begin
         tx_mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers, occupancy and the sticky halt/overflow flags; pointers wrap naturally.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tx_cnt      <= '0;
         tx_overflow <= 1'b0;
         sim_halt    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WID'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WID'(1);
         end
         case ({push, pop})
            2'b10:   tx_cnt <= tx_cnt + CNT_WID'(1);
            2'b01:   tx_cnt <= tx_cnt - CNT_WID'(1);
            default: tx_cnt <= tx_cnt;
         endcase
         if (push_req && !push) begin
            tx_overflow <= 1'b1;
         end
         if (halt_wr) begin
            sim_halt <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: table-driven RAM/I/O vectors plus hand-written sequences
// for the UART FIFO, RX register, cycle counter and halt/reset behaviour.
// Read expectations and expected TX bytes are queued when stimulus is driven
// and compared when the DUT produces them.
`timescale 1ns/1ps

module tb_mem_io_responder;

   localparam int TX_DEPTH = 8;

`ifdef MEM_IO_CLK_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        sim_halt;
   logic        tx_overflow;

   always #5 clk_in = ~clk_in;

   mem_io_responder #(
      .MEM_ADDR_WID(17),
      .TX_DEPTH    (TX_DEPTH)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .mem_a         (mem_a),
      .mem_wr        (mem_wr),
      .mem_dout      (mem_dout),
      .mem_din       (mem_din),
      .io_buffer_full(io_buffer_full),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .sim_halt      (sim_halt),
      .tx_overflow   (tx_overflow)
   );

   typedef struct {
      string      name;
      logic [7:0] exp;
   } rd_exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] a;
      logic [7:0]  d;
      bit          chk;
      logic [7:0]  exp;
      string       name;
   } vec_t;

   rd_exp_t     rdq[$];
   logic [7:0]  txq[$];
   vec_t        vecs[$];
   int          n_pass  = 0;
   int          n_total = 0;
   bit          rd_issued = 1'b0;
   logic [31:0] model_cnt = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One clock: compare any TX byte leaving the FIFO, cross the edge, then compare read data.
   task automatic cycle();
      rd_exp_t e;
      if (tx_valid === 1'b1 && tx_ready) begin
         if (txq.size() == 0) begin
            n_total++;
            $display("FAIL tx_unexpected_byte: got 0x%0h, expected no byte", tx_data);
         end else begin
            check("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
         end
      end
      @(posedge clk_in);
      if (rst_in) model_cnt = 32'd0;
      else        model_cnt = model_cnt + 32'd1;
      #1;
      if (rd_issued) begin
         e = rdq.pop_front();
         check(e.name, 32'(mem_din), 32'(e.exp));
      end
      rd_issued = 1'b0;
   endtask

   task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] d,
                         input bit chk, input logic [7:0] exp, input string name);
      mem_wr   = wr;
      mem_a    = a;
      mem_dout = d;
      if (chk) begin
         rdq.push_back('{name, exp});
         rd_issued = 1'b1;
      end
      cycle();
   endtask

   task automatic idle(input int n);
      repeat (n) access(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "");
   endtask

   task automatic do_reset(input int n);
      rst_in = 1'b1;
      idle(n);
      rst_in = 1'b0;
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap;
      logic [31:0] assembled;

      rst_in   = 1'b1;
      mem_a    = 32'h0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      // ---------------- reset state ----------------
      do_reset(3);
      check("rst_mem_din",        32'(mem_din), 32'h0);
      check("rst_tx_valid",       32'(tx_valid), 32'h0);
      check("rst_rx_ready",       32'(rx_ready), 32'h1);
      check("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
      check("rst_sim_halt",       32'(sim_halt), 32'h0);
      check("rst_tx_overflow",    32'(tx_overflow), 32'h0);

      // ---------------- RAM / decode vectors ----------------
      vecs.push_back('{1'b1, 32'h00123,    8'hA5, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 32'h00123,    8'h00, 1'b1, 8'hA5, "rd_after_wr_123"});
      vecs.push_back('{1'b1, 32'h1FFFF,    8'h3C, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b1, 32'h00000,    8'h81, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 32'h1FFFF,    8'h00, 1'b1, 8'h3C, "rd_top_of_ram"});
      vecs.push_back('{1'b0, 32'h00000,    8'h00, 1'b1, 8'h81, "rd_bottom_of_ram"});
      vecs.push_back('{1'b1, 32'h10008,    8'h5A, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b1, 32'h30008,    8'hFF, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 32'h10008,    8'h00, 1'b1, 8'h5A, "ram_untouched_by_io_wr"});
      vecs.push_back('{1'b0, 32'h30008,    8'h00, 1'b1, 8'h00, "rd_unmapped_io"});
      vecs.push_back('{1'b0, 32'h20123,    8'h00, 1'b1, 8'hA5, "rd_alias_above_ram"});
      vecs.push_back('{1'b1, 32'h00123,    8'h77, 1'b0, 8'h00, ""});
      vecs.push_back('{0,    32'h00123,    8'h00, 1'b1, 8'h77, "rd_after_rewrite"});
      vecs.push_back('{1'b0, 32'hFFF00123, 8'h00, 1'b1, 8'h77, "rd_upper_bits_ignored"});
      vecs.push_back('{1'b0, 32'h30000,    8'h00, 1'b1, 8'h00, "rd_rx_empty"});
      vecs.push_back('{1'b1, 32'h00200,    8'h11, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 32'h00200,    8'h00, 1'b1, 8'h11, "rd_200"});
      for (int i = 0; i < vecs.size(); i++) begin
         access(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].chk, vecs[i].exp, vecs[i].name);
      end

      // ---------------- TX basic: zero writes filtered ----------------
      tx_ready = 1'b1;
      access(1'b1, 32'h30000, 8'h41, 1'b0, 8'h00, ""); txq.push_back(8'h41);
      access(1'b1, 32'h30000, 8'h00, 1'b0, 8'h00, "");
      access(1'b1, 32'h30000, 8'h42, 1'b0, 8'h00, ""); txq.push_back(8'h42);
      idle(4);
      check("tx_basic_drained", 32'(txq.size()), 32'd0);
      check("tx_basic_idle",    32'(tx_valid), 32'h0);

      // ---------------- RX register ----------------
      check("rx_ready_idle", 32'(rx_ready), 32'h1);
      rx_valid = 1'b1; rx_data = 8'h7E;
      idle(1);
      rx_valid = 1'b0;
      check("rx_ready_after_load", 32'(rx_ready), 32'h0);
      access(1'b0, 32'h30000, 8'h00, 1'b1, 8'h7E, "rd_rx_7e");
      access(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rd_rx_again");
      check("rx_ready_after_read", 32'(rx_ready), 32'h1);
      rx_valid = 1'b1; rx_data = 8'h55;
      access(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rd_rx_during_load");
      rx_data = 8'h99;
      access(1'b0, 32'h30000, 8'h00, 1'b1, 8'h55, "rd_rx_kept_new");
      rx_valid = 1'b0;
      access(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rd_rx_no_load_when_full");
      check("rx_ready_end", 32'(rx_ready), 32'h1);

      // ---------------- TX fill, threshold, overflow ----------------
      tx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         access(1'b1, 32'h30000, 8'(i), 1'b0, 8'h00, "");
         txq.push_back(8'(i));
         if (i == 5) check("iobuf_full_after_5", 32'(io_buffer_full), 32'h0);
      end
      check("iobuf_full_after_6", 32'(io_buffer_full), 32'h1);
      access(1'b1, 32'h30000, 8'h07, 1'b0, 8'h00, ""); txq.push_back(8'h07);
      access(1'b1, 32'h30000, 8'h08, 1'b0, 8'h00, ""); txq.push_back(8'h08);
      check("overflow_at_8", 32'(tx_overflow), 32'h0);
      access(1'b1, 32'h30000, 8'h09, 1'b0, 8'h00, "");
      check("overflow_on_drop", 32'(tx_overflow), 32'h1);
      // Full FIFO with a pop in the same cycle must still take the push.
      tx_ready = 1'b1;
      access(1'b1, 32'h30000, 8'h0A, 1'b0, 8'h00, ""); txq.push_back(8'h0A);
      check("overflow_sticky", 32'(tx_overflow), 32'h1);
      idle(TX_DEPTH + 4);
      check("tx_full_drained", 32'(txq.size()), 32'd0);
      check("tx_full_idle",    32'(tx_valid), 32'h0);
      check("iobuf_after_drain", 32'(io_buffer_full), 32'h0);

      // ---------------- cycle counter ----------------
      do_reset(2);
      check("rst2_tx_overflow", 32'(tx_overflow), 32'h0);
      idle(100);
      snap = model_cnt;
      assembled = 32'h0;
      for (int k = 0; k < 4; k++) begin
         access(1'b0, 32'h30004 + 32'(k), 8'h00, 1'b1,
                CNT_EN ? snap[8*k +: 8] : 8'h00, "rd_clk_byte");
         assembled[8*k +: 8] = mem_din;
      end
      check("clk_assembled_100", assembled, CNT_EN ? 32'd100 : 32'd0);
      idle(148);
      snap = model_cnt;
      access(1'b0, 32'h30004, 8'h00, 1'b1, CNT_EN ? snap[7:0] : 8'h00, "rd_clk_b0_late");
      idle(10);
      access(1'b0, 32'h30005, 8'h00, 1'b1, CNT_EN ? snap[15:8] : 8'h00, "rd_clk_b1_snapshot");
      access(1'b0, 32'h30007, 8'h00, 1'b1, CNT_EN ? snap[31:24] : 8'h00, "rd_clk_b3_snapshot");

      // ---------------- halt and mid-stream reset ----------------
      tx_ready = 1'b1;
      check("halt_before", 32'(sim_halt), 32'h0);
      access(1'b1, 32'h30004, 8'h5A, 1'b0, 8'h00, ""); txq.push_back(8'h00);
      check("halt_set", 32'(sim_halt), 32'h1);
      idle(3);
      check("halt_byte_sent", 32'(txq.size()), 32'd0);
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) access(1'b1, 32'h30000, 8'h61 + 8'(i), 1'b0, 8'h00, "");
      check("stream_pending", 32'(tx_valid), 32'h1);
      rst_in = 1'b1;
      access(1'b1, 32'h00200, 8'hEE, 1'b0, 8'h00, "");
      rst_in = 1'b0;
      check("midrst_tx_valid", 32'(tx_valid), 32'h0);
      check("midrst_sim_halt", 32'(sim_halt), 32'h0);
      check("midrst_mem_din",  32'(mem_din), 32'h0);
      tx_ready = 1'b1;
      idle(3);
      access(1'b0, 32'h00200, 8'h00, 1'b1, 8'h11, "ram_kept_and_rst_write_ignored");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WID, default 17, giving a RAM of 2^MEM_ADDR_WID bytes (128 KB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, giving the UART transmit FIFO depth in bytes (power of two, >=4).
REQ-003 SHALL have port clk_in, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_a, input, 32: byte address from the CPU; only bits 17:0 are decoded.
REQ-006 SHALL have port mem_wr, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port mem_dout, input, 8: write data from the CPU.
REQ-008 SHALL have port mem_din, output, 8: read data to the CPU.
REQ-009 SHALL have port io_buffer_full, output, 1: tells the CPU to stop issuing UART writes.
REQ-010 SHALL have ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1): UART transmit byte stream.
REQ-011 SHALL have ports rx_valid (input, 1), rx_data (input, 8) and rx_ready (output, 1): UART receive byte stream.
REQ-012 SHALL have ports sim_halt (output, 1: sticky program-stop flag) and tx_overflow (output, 1: sticky dropped-byte flag).

Function
REQ-013 SHALL accept one access every cycle; there is no request valid signal and there are no wait states.
REQ-014 SHALL treat an address as I/O when mem_a[17:16]==2'b11; every other address SHALL access RAM at index mem_a[MEM_ADDR_WID-1:0].
REQ-015 SHALL present read data on mem_din in the cycle after the address (read latency exactly 1); a write SHALL complete in its own cycle.
REQ-016 SHALL return the newly written byte when a RAM read follows a write to the same address in the next cycle (ordinary RAM ordering).
REQ-017 SHALL, on a write to 0x30000 with mem_dout!=0, push mem_dout into the TX FIFO.
REQ-018 SHALL ignore a write of 0x00 to 0x30000: no push and no state change.
REQ-019 SHALL, on a read of 0x30000, return the byte held in the RX register and empty that register; if the register is empty the read SHALL return 0x00.
REQ-020 SHALL load the RX register from rx_data when rx_valid && rx_ready; rx_ready = RX register empty.
REQ-021 SHALL, when a read and a load of the RX register happen in the same cycle, return the old byte and keep the new one.
REQ-022 SHALL, on a read of 0x30004+k (k=0..3), return byte k of the 32-bit cycle counter, little-endian.
REQ-023 SHALL snapshot the counter on a read with k==0; reads with k=1..3 SHALL use that snapshot.
REQ-024 SHALL increment the counter every cycle after reset and let it wrap at 2^32.
REQ-025 SHALL, on a write to 0x30004, set sim_halt and push 0x00 into the TX FIFO; the zero-filter of REQ-018 does not apply to this push.
REQ-026 SHALL read 0x00 from any other I/O address and ignore writes to it.
REQ-027 SHALL drive the TX FIFO head on tx_data with tx_valid = FIFO not empty; the head pops when tx_valid && tx_ready.
REQ-028 SHALL let a push and a pop occur in the same cycle, leaving occupancy unchanged.
REQ-029 SHALL assert io_buffer_full combinationally while occupancy >= TX_DEPTH-2, leaving slack for a write already in flight.
REQ-030 SHALL drop a push made while the FIFO is full (occupancy TX_DEPTH with no simultaneous pop) and set tx_overflow.
REQ-031 SHALL wrap the FIFO read and write pointers modulo TX_DEPTH.

Reset
REQ-032 SHALL, on rst_in, clear mem_din, the counter, the snapshot, the FIFO pointers and occupancy, the RX register, sim_halt and tx_overflow.
REQ-033 SHALL not clear RAM contents on reset.
REQ-034 SHALL ignore CPU accesses in a reset cycle.
REQ-035 SHALL present tx_valid=0, rx_ready=1 and io_buffer_full=0 in the cycle after reset.

Configuration
REQ-036 SHALL, with MEM_IO_CLK_CNT_EN defined, implement the counter and snapshot of REQ-022..024.
REQ-037 SHALL, without MEM_IO_CLK_CNT_EN, omit the counter registers and return 0x00 for reads of 0x30004..0x30007; halt behaviour is unchanged.

Verification
REQ-038 SHALL verify: write 0xA5 to 0x00123, read 0x00123 next cycle -> mem_din==0xA5 one cycle after the read address.
REQ-039 SHALL verify: writes 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data carries exactly 0x41 then 0x42.
REQ-040 SHALL verify: tx_ready=0, six nonzero writes to 0x30000 (TX_DEPTH=8) -> io_buffer_full rises after the 6th; 3 more writes -> tx_overflow=1 and occupancy==8.
REQ-041 SHALL verify (MEM_IO_CLK_CNT_EN): 100 cycles after reset, read 0x30004..0x30007 -> bytes assemble to the value captured at the 0x30004 read (~100).
REQ-042 SHALL verify: rx_valid with 0x7E, then read 0x30000 -> 0x7E; a second read -> 0x00; rx_ready returns to 1.
REQ-043 SHALL verify: write to 0x30004 -> sim_halt=1 next cycle and 0x00 appears on tx_data; rst_in mid-stream -> tx_valid=0 and sim_halt=0.
